left_rotator_seq: RTL and testbench
===================================

// Module: left_rotator_seq
// PURPOSE
//   Multi-cycle left barrel rotator with valid/ready handshakes on input and output.
//   Each input word is rotated left by in_amt positions, one log2 stage per clock.
//   It is the left-direction companion of the combinational right rotator in the
//   MultiFunction_BarrelShifter design. It feeds registered, back-pressurable
//   results to the downstream mux/display logic.
// PARAMETERS
//   N  8  data width in bits; must equal 2**M
//   M  3  rotate-amount width; also the number of rotate stages
// PORTS
//   clk        input   1  system clock; all state updates on rising edge
//   reset      input   1  synchronous, active-high reset
//   in_valid   input   1  in_data/in_amt valid this cycle
//   in_ready   output  1  block can accept a word this cycle
//   in_data    input   N  word to rotate
//   in_amt     input   M  left-rotate amount, 0..N-1
//   out_valid  output  1  out_data holds a finished result
//   out_ready  input   1  downstream accepts out_data this cycle
//   out_data   output  N  rotated word, registered
//   busy       output  1  high in ROT or HOLD
// BEHAVIOUR
//   Reset (reset=1 at a clk edge)
//     - state <= IDLE; data_r, amt_r and stage counter k cleared to 0.
//     - out_valid=0, out_data=0, busy=0.
//     - in_ready=0 while reset is high.
//     - Reset wins over every other event, including mid-ROT and mid-HOLD.
//     - An in-flight word is discarded; no out_valid pulse is produced for it.
//   FSM states: IDLE, ROT, HOLD
//     - IDLE: in_ready=1. On in_valid&in_ready:
//       data_r<=in_data, amt_r<=in_amt, k<=0, go to ROT.
//     - ROT: in_ready=0; in_valid is ignored. Each cycle:
//       if amt_r[k], data_r <= {data_r[N-1-2**k:0], data_r[N-1:N-2**k]}; else hold.
//       k<=k+1. When k==M-1 the stage completes and the FSM goes to HOLD.
//     - HOLD: out_valid=1, out_data=data_r, both stable until the handshake.
//       On out_ready, go to IDLE. out_valid drops the following cycle.
//   Latency
//     - Accept edge at cycle t -> out_valid=1 from cycle t+M.
//     - Latency is fixed at M cycles regardless of in_amt, including in_amt=0.
//   Throughput
//     - One word per M+2 cycles minimum; there is no overlap of words.
//     - in_ready is never high while out_valid is high.
//   Handshake rules
//     - in_ready is a decode of state (IDLE) gated by !reset.
//     - in_ready does not depend on in_valid.
//     - out_valid must not depend on out_ready.
//     - out_ready asserted outside HOLD has no effect.
//   Width rules
//     - Amount is taken modulo N by construction; M bits cover 0..N-1.
//     - Stage k rotates by exactly 2**k. No bits are lost (pure rotate, not shift).
//   Cross-stage
//     - Equivalent result: out_data == (x<<a)|(x>>(N-a)) for a>0, and x for a=0.
// TESTING (N=8, M=3)
//   - 8'h81, amt=1 -> out_data=8'h03, out_valid rises exactly 3 cycles after accept.
//   - 8'hB4, amt=3 -> 8'hA5; 8'h01, amt=7 -> 8'h80; 8'h5A, amt=0 -> 8'h5A after 3 cycles.
//   - Hold out_ready=0 for 5 cycles in HOLD -> out_data/out_valid stable;
//     in_ready=0 throughout; new in_valid ignored.
//   - Assert reset 1 cycle during ROT (k=1) -> next cycle IDLE, out_valid=0, out_data=0,
//     in_ready=1 after release; no stale result ever appears.
//   - Back-to-back in_valid held high with out_ready=1 -> words accepted every 5 cycles,
//     results in order.
//   - Exhaustive 256 values x 8 amounts with random out_ready stalls
//     -> matches golden rotl model; 2048 results, no drops or duplicates.

Source files
------------

// File: rtl/left_rotator_seq.sv
// Multi-cycle left barrel rotator: one log2 rotate stage per clock, valid/ready on both sides.
// A word is accepted in IDLE, rotated over M cycles in ROT, then presented in HOLD until taken.
module left_rotator_seq #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [M-1:0] in_amt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Handshake contract: a transfer happens on a rising edge where valid && ready.
  // in_ready is a pure decode of state (gated by reset) and out_valid never looks at out_ready.

  state_t         state, state_nxt;
  logic [N-1:0]   data_r, data_nxt;
  logic [M-1:0]   amt_r, amt_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic [N-1:0]   rot_stage;

  // Stage k rotates by exactly 2**k; the shift pair keeps every bit.
  always_comb begin
    rot_stage = (data_r << (1 << k)) | (data_r >> (N - (1 << k)));
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_r;
    amt_nxt   = amt_r;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_nxt  = in_data;
          amt_nxt   = in_amt;
          k_nxt     = '0;
          state_nxt = ROT;
        end
      end
      ROT: begin
        if (amt_r[k]) begin
          data_nxt = rot_stage;
        end
        k_nxt = k + 1'b1;
        if (k == KW'(M - 1)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_r <= '0;
      amt_r  <= '0;
      k      <= '0;
    end else begin
      state  <= state_nxt;
      data_r <= data_nxt;
      amt_r  <= amt_nxt;
      k      <= k_nxt;
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == HOLD);
  assign out_data  = data_r;
  assign busy      = (state == ROT) || (state == HOLD);

endmodule

// File: tb/tb_left_rotator_seq.sv
// Bench for left_rotator_seq (N=8, M=3): directed vector table, stall/reset/back-to-back
// sequences, and an exhaustive sweep with random output stalls against a rotl model.
module tb_left_rotator_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  left_rotator_seq #(.N(8), .M(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [7:0] rotl(logic [7:0] x, logic [2:0] a);
    if (a == 3'd0) return x;
    return (x << a) | (x >> (4'd8 - {1'b0, a}));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_in_ready(output bit ok);
    int c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    ok = in_ready;
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  bit         mon_en = 0;
  bit         b2b_en = 0;
  bit         have_acc = 0;
  int         last_acc = 0;
  int         results = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (prev_hold) begin
        check("hold_valid_stable", out_valid, 1);
        check("hold_data_stable", out_data, prev_data);
      end
      check("ready_while_valid", in_ready && out_valid, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(rotl(in_data, in_amt));
        if (b2b_en && have_acc) check("b2b_spacing", cyc_cnt - last_acc, 5);
        last_acc = cyc_cnt;
        have_acc = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("result_unexpected", 1, 0);
        else check("result_data", out_data, exp_q.pop_front());
        results++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end else begin
      prev_hold = 0;
    end
  end

  task automatic drain();
    int c = 0;
    in_valid  = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    bit         ok;
    int         lat;
    bit         seen;

    vecs[0] = '{8'h81, 3'd1, 8'h03};
    vecs[1] = '{8'hB4, 3'd3, 8'hA5};
    vecs[2] = '{8'h01, 3'd7, 8'h80};
    vecs[3] = '{8'h5A, 3'd0, 8'h5A};
    vecs[4] = '{8'h0F, 3'd4, 8'hF0};
    vecs[5] = '{8'hC3, 3'd2, 8'h0F};
    vecs[6] = '{8'h80, 3'd1, 8'h01};
    vecs[7] = '{8'hFF, 3'd5, 8'hFF};
    vecs[8] = '{8'h12, 3'd6, 8'h84};

    reset     = 1;
    in_valid  = 0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 0;
    @(posedge clk); #1;
    check("rst_release_in_ready", in_ready, 1);

    // directed vector table
    foreach (vecs[i]) begin
      wait_in_ready(ok);
      check("vec_in_ready", ok, 1);
      in_valid = 1;
      in_data  = vecs[i].data;
      in_amt   = vecs[i].amt;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("vec_latency", lat, 3);
      check("vec_data", out_data, vecs[i].exp);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("vec_valid_drop", out_valid, 0);
    end

    // stall in HOLD for 5 cycles with a competing input word
    wait_in_ready(ok);
    in_valid = 1; in_data = 8'h3C; in_amt = 3'd2;
    @(posedge clk); #1;
    in_data = 8'hAA; in_amt = 3'd1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_latency", lat, 3);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 8'hF0);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("stall_release_valid", out_valid, 0);
    check("stall_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("stall_no_extra_accept", busy, 0);

    // reset while in ROT with k=1
    wait_in_ready(ok);
    in_valid = 1; in_data = 8'h81; in_amt = 3'd7;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("midrot_busy", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    check("midrot_out_valid", out_valid, 0);
    check("midrot_out_data", out_data, 0);
    check("midrot_busy_cleared", busy, 0);
    check("midrot_in_ready_in_reset", in_ready, 0);
    reset = 0;
    #1;
    check("midrot_in_ready_after", in_ready, 1);
    out_ready = 1;
    seen = 0;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("midrot_no_stale", seen, 0);
    out_ready = 0;

    // back-to-back with in_valid held high
    mon_en   = 1;
    b2b_en   = 1;
    have_acc = 0;
    results  = 0;
    out_ready = 1;
    in_valid  = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = vecs[i].data;
      in_amt  = vecs[i].amt;
      wait_in_ready(ok);
      check("b2b_in_ready", ok, 1);
      @(posedge clk); #1;
    end
    drain();
    check("b2b_result_count", results, 6);
    b2b_en = 0;

    // exhaustive sweep with random out_ready stalls
    results = 0;
    in_valid = 1;
    for (int v = 0; v < 256; v++) begin
      for (int a = 0; a < 8; a++) begin
        logic [7:0] vd;
        logic [2:0] ad;
        int c;
        vd = v[7:0];
        ad = a[2:0];
        in_data = vd;
        in_amt  = ad;
        c = 0;
        while (!in_ready && c < 100) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          c++;
        end
        if (!in_ready) check("sweep_in_ready_timeout", 0, 1);
        @(posedge clk); #1;
      end
    end
    drain();
    check("sweep_result_count", results, 2048);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
